// File: rtl/i2s_stereo_window_rx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_stereo_window_rx_pkg
// Purpose : shared definitions for the stereo I2S window receiver.
// Contents: I2S_LEFT word-select level and the receiver FSM state type.
// ---------------------------------------------------------------------------
package i2s_stereo_window_rx_pkg;

  // Word-select level that marks the left channel slot (Philips I2S).
  localparam logic I2S_LEFT = 1'b0;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge
// Purpose : brings asynchronous I2S pins into the clk domain.
//   i_edge  : pin whose rising edge is detected (I2S bit clock)
//   i_async : companion pins that only need synchronising (ws, sd)
// Ports:
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_edge         : async edge pin
//   i_async[W-1:0] : async data pins
//   o_sync[W-1:0]  : synchronised data pins, time-aligned with o_rise
//   o_rise         : one-cycle flag, registered, for a synced 0->1 on i_edge
// ---------------------------------------------------------------------------
module i2s_sync_edge #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_edge,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_rise
);

  // [0] metastability stage, [1] synchronised, [2] one cycle older
  logic [2:0]       r_edge_sh;
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_dly;
  logic             r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_sh <= '0;
      r_meta    <= '0;
      r_sync    <= '0;
      r_dly     <= '0;
      r_rise    <= 1'b0;
    end else begin
      r_edge_sh <= {r_edge_sh[1:0], i_edge};
      r_meta    <= i_async;
      r_sync    <= r_meta;
      // The data path carries one extra stage so that, in the cycle the
      // registered rise flag is high, o_sync shows the pins as they were
      // when the synchronised edge pin went high.
      r_dly     <= r_sync;
      r_rise    <= r_edge_sh[1] & ~r_edge_sh[2];
    end
  end

  assign o_sync = r_dly;
  assign o_rise = r_rise;

endmodule

// File: rtl/i2s_stereo_window_rx.sv
// ---------------------------------------------------------------------------
// i2s_stereo_window_rx
// Purpose : deserialises one stereo Philips-I2S stream into left/right
//           sample pairs, strobes each complete pair and numbers the pairs
//           within windows of WINDOW_SAMPLES for the beam-forming stage.
// Ports:
//   clk             : system clock (>= 4x i2s_sck)
//   reset_n         : async active-low reset (deassertion synchronised here)
//   enable          : 0 holds the receiver idle and forces a resync
//   i2s_sck/ws/sd   : asynchronous I2S pins (ws 0 = left)
//   left_data_out   : last complete left sample
//   right_data_out  : last complete right sample
//   sample_valid    : one-cycle strobe, new pair on the data outputs
//   sample_index    : position of the presented pair in its window
//   window_done     : strobes with the last pair of a window
//   frame_error     : one-cycle strobe, slot length differed from SLOT_WIDTH
// ---------------------------------------------------------------------------
module i2s_stereo_window_rx
  import i2s_stereo_window_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SLOT_WIDTH     = 32,
  parameter int WINDOW_SAMPLES = 90
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              i2s_sck,
  input  logic                              i2s_ws,
  input  logic                              i2s_sd,
  output logic [DATA_WIDTH-1:0]             left_data_out,
  output logic [DATA_WIDTH-1:0]             right_data_out,
  output logic                              sample_valid,
  output logic [$clog2(WINDOW_SAMPLES)-1:0] sample_index,
  output logic                              window_done,
  output logic                              frame_error
);

  // One spare bit lets the saturating counter tell an over-long slot apart
  // from a correct one.
  localparam int CNT_W = $clog2(SLOT_WIDTH) + 1;
  localparam int IDX_W = $clog2(WINDOW_SAMPLES);

  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WINDOW_SAMPLES - 1);

  // Reset: asserted asynchronously, released on clk.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Pin synchronisation: sck provides the rise flag, ws/sd ride along.
  logic [1:0] w_pins_s;
  logic       w_sck_rise;
  logic       w_ws_s;
  logic       w_sd_s;

  i2s_sync_edge #(
    .WIDTH (2)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (w_rst_n),
    .i_edge  (i2s_sck),
    .i_async ({i2s_sd, i2s_ws}),
    .o_sync  (w_pins_s),
    .o_rise  (w_sck_rise)
  );

  assign w_ws_s = w_pins_s[0];
  assign w_sd_s = w_pins_s[1];

  // Slot tracking
  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic                  r_ws_prev;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_left_hold;
  logic [IDX_W-1:0]      r_next_idx;

  logic                  w_ws_edge;
  logic                  w_slot_ok;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_latch_left;
  logic                  w_pair_good;
  logic                  w_frame_err;

  // A ws change at rise k means bit k is the LSB of the slot being closed.
  assign w_ws_edge = w_ws_s ^ r_ws_prev;
  assign w_slot_ok = (r_bit_cnt == SLOT_LAST);
  // Word including the current bit; bits past DATA_WIDTH are dropped.
  assign w_word    = (r_bit_cnt < DATA_BITS) ? {r_shift[DATA_WIDTH-2:0], w_sd_s}
                                             : r_shift;

  always_comb begin
    w_state_nxt  = r_state;
    w_latch_left = 1'b0;
    w_pair_good  = 1'b0;
    w_frame_err  = 1'b0;
    if (!enable) begin
      w_state_nxt = SYNC_WAIT;
    end else if (w_sck_rise && w_ws_edge) begin
      case (r_state)
        SYNC_WAIT: begin
          if (w_ws_s == I2S_LEFT) w_state_nxt = LEFT;
        end
        LEFT: begin
          if (w_slot_ok) begin
            w_latch_left = 1'b1;
            w_state_nxt  = RIGHT;
          end else begin
            w_frame_err  = 1'b1;
            w_state_nxt  = SYNC_WAIT;
          end
        end
        RIGHT: begin
          if (w_slot_ok) begin
            w_pair_good  = 1'b1;
            w_state_nxt  = LEFT;
          end else begin
            w_frame_err  = 1'b1;
            w_state_nxt  = SYNC_WAIT;
          end
        end
        default: w_state_nxt = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= SYNC_WAIT;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ws_prev      <= 1'b0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_left_hold    <= '0;
      r_next_idx     <= '0;
      left_data_out  <= '0;
      right_data_out <= '0;
      sample_valid   <= 1'b0;
      sample_index   <= '0;
      window_done    <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      window_done  <= 1'b0;
      frame_error  <= 1'b0;
      // ws history keeps running while disabled so that only a ws edge
      // seen after enable returns can start a capture.
      if (w_sck_rise) r_ws_prev <= w_ws_s;

      if (!enable) begin
        r_bit_cnt    <= '0;
        r_shift      <= '0;
        r_next_idx   <= '0;
        sample_index <= '0;
      end else begin
        if (w_sck_rise) begin
          if (w_ws_edge) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end else begin
            r_shift <= w_word;
            if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        if (w_latch_left) r_left_hold <= w_word;

        if (w_pair_good) begin
          left_data_out  <= r_left_hold;
          right_data_out <= w_word;
          sample_valid   <= 1'b1;
          sample_index   <= r_next_idx;
          window_done    <= (r_next_idx == IDX_LAST);
          r_next_idx     <= (r_next_idx == IDX_LAST) ? '0 : r_next_idx + 1'b1;
        end

        if (w_frame_err) frame_error <= 1'b1;
      end
    end
  end

endmodule
